usb_tx_pkt: RTL

USB low-speed device packet encoder, directly upstream of the serializer (`usb_tx`). On a start request it emits a handshake packet (PID only) or a data packet (PID, 0–8 payload bytes, CRC16) as a byte stream on the serializer's `data`/`valid`/`ready` handshake. Payload bytes are read from the endpoint buffer through a synchronous read port. The serializer itself generates SYNC, bit stuffing, NRZI and EOP.

---
 rtl/usb_tx_pkt_pkg.sv | 44 ++++
 rtl/usb_tx_pkt_crc16.sv | 40 ++++
 rtl/usb_tx_pkt.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_pkt_pkg.sv
// Shared types for the USB low-speed transmit packet path: PID codes, CRC16 constants,
// encoder state enum and a byte-wide reflected CRC16 step function.
// Imported by usb_tx_pkt and usb_crc16 (the latter is reused by the receive path).
package usb_tx_pkt_pkg;

  typedef enum logic [3:0] {
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_e;

  // Generator polynomial x^16+x^15+x^2+1; bits go out LSB-first, so the
  // shift register runs in the reflected form.
  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_GUARD
  } state_e;

  // DATA0 and DATA1 differ only in bit 3.
  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid[2:0] == PID_DATA0[2:0]);
  endfunction

  // One payload byte folded into the reflected CRC16, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_tx_pkt_crc16.sv
// usb_crc16: byte-wide USB CRC16 (reflected 0xA001, init 0xFFFF) with state register.
// clear has priority over en; crc_nxt_o is the combinational value after folding data_i.
// Register output is updated one cycle after en; reused by the receive path.
module usb_crc16
  import usb_tx_pkt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o,
  output logic [15:0] crc_nxt_o
);

  logic [15:0] crc_q, crc_d;

  // Next CRC: clear reloads the init value, en folds in one byte.
  always_comb begin
    crc_nxt_o = crc16_byte(crc_q, data_i);
    crc_d     = crc_q;
    if (clear_i) begin
      crc_d = CRC16_INIT;
    end else if (en_i) begin
      crc_d = crc_nxt_o;
    end
  end

  // CRC state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usb_tx_pkt.sv
// usb_tx_pkt: USB low-speed packet encoder (PID / payload / CRC16 bytes to the serializer).
// Latency: PID on tx_data one cycle after pkt_start; payload bytes land 2 cycles after tx_ready.
// Backpressure: each byte is held with tx_valid until a tx_ready pulse; USB_TX_PKT_TOGGLE_EN adds the data-toggle bit.
module usb_tx_pkt
  import usb_tx_pkt_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 224
) (
  input  logic       clk,
  input  logic       reset,
`ifdef USB_TX_PKT_TOGGLE_EN
  input  logic       toggle_adv,
  input  logic       toggle_clr,
`endif
  input  logic       pkt_start,
  input  logic [3:0] pkt_pid,
  input  logic [3:0] pkt_len,
  output logic [2:0] pl_addr,
  input  logic [7:0] pl_rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       pkt_done
);

  // busy drops on the cycle the counter reaches this value (counter starts at 1).
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  pid_q, pid_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic        fetch_q, fetch_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [2:0]  pl_addr_q, pl_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] gcnt_q, gcnt_d;

  logic        crc_clear, crc_en;
  logic [15:0] crc, crc_nxt;
  logic [3:0]  start_pid, start_len;

`ifdef USB_TX_PKT_TOGGLE_EN
  logic toggle_q, toggle_d;

  // Data toggle: clear wins over advance.
  always_comb begin
    toggle_d = toggle_q;
    if (toggle_clr) begin
      toggle_d = 1'b0;
    end else if (toggle_adv) begin
      toggle_d = ~toggle_q;
    end
  end

  // Toggle register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign start_pid = is_data_pid(pkt_pid) ? {toggle_q, pkt_pid[2:0]} : pkt_pid;
`else
  assign start_pid = pkt_pid;
`endif

  assign start_len = (pkt_len > 4'd8) ? 4'd8 : pkt_len;

  usb_crc16 u_crc (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (crc_clear),
    .en_i      (crc_en),
    .data_i    (tx_data_q),
    .crc_o     (crc),
    .crc_nxt_o (crc_nxt)
  );

  // Next-state and output logic. In DATA, fetch_q marks the cycle where pl_rdata
  // holds the byte addressed during the tx_ready cycle and is loaded into tx_data.
  always_comb begin
    state_d    = state_q;
    pid_d      = pid_q;
    len_d      = len_q;
    idx_d      = idx_q;
    fetch_d    = fetch_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    pl_addr_d  = pl_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    gcnt_d     = gcnt_q;
    crc_clear  = 1'b0;
    crc_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pkt_start) begin
          pid_d      = start_pid;
          len_d      = start_len;
          idx_d      = 4'd0;
          fetch_d    = 1'b0;
          pl_addr_d  = 3'd0;
          tx_data_d  = {~start_pid, start_pid};
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          crc_clear  = 1'b1;
          state_d    = ST_PID;
        end
      end
      ST_PID: begin
        if (tx_ready) begin
          if (!is_data_pid(pid_q)) begin
            tx_valid_d = 1'b0;
            gcnt_d     = 16'd1;
            state_d    = ST_GUARD;
          end else if (len_q != 4'd0) begin
            fetch_d = 1'b1;
            state_d = ST_DATA;
          end else begin
            tx_data_d = ~crc[7:0];
            state_d   = ST_CRC_LO;
          end
        end
      end
      ST_DATA: begin
        if (fetch_q) begin
          tx_data_d = pl_rdata;
          pl_addr_d = pl_addr_q + 3'd1;
          fetch_d   = 1'b0;
        end else if (tx_ready) begin
          crc_en = 1'b1;
          idx_d  = idx_q + 4'd1;
          if ((idx_q + 4'd1) == len_q) begin
            tx_data_d = ~crc_nxt[7:0];
            state_d   = ST_CRC_LO;
          end else begin
            fetch_d = 1'b1;
          end
        end
      end
      ST_CRC_LO: begin
        if (tx_ready) begin
          tx_data_d = ~crc[15:8];
          state_d   = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          gcnt_d     = 16'd1;
          state_d    = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (gcnt_q == GUARD_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the packet immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pid_q      <= 4'd0;
      len_q      <= 4'd0;
      idx_q      <= 4'd0;
      fetch_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      pl_addr_q  <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gcnt_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      fetch_q    <= fetch_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      pl_addr_q  <= pl_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gcnt_q     <= gcnt_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign pl_addr  = pl_addr_q;
  assign busy     = busy_q;
  assign pkt_done = done_q;

endmodule
